mem_fifo_scheduler: RTL

//  Sequences the shared 16x24 sample memory as a circular FIFO between the UART writer and the SPI sender.

---
 rtl/mem_fifo_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_fifo_scheduler.sv
// Circular-FIFO sequencer for the shared sample memory: arbitrates the single port between
// UART-side writes and SPI-side reads, and handshakes load_data/done_send with the SPI sender.
module mem_fifo_scheduler #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk_div,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              send_en_n,
  input  logic              flush,
  input  logic              done_send,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              load_data,
  output logic [ADDR_W-1:0] count,
  output logic              empty,
  output logic              full,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] DepthW  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LastPtr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StLoad, StWait} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, wr_ack_q, load_data_q, busy_q;
  logic                last_grant_wr_q, last_grant_wr_d;
  logic                wr_elig, rd_elig, accept, pop, start_rd, flush_now;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == DepthW);

  assign wr_elig = wr_req && !full && !wr_ack_q;
  assign rd_elig = !send_en_n && !empty;

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    pop             = 1'b0;
    start_rd        = 1'b0;
    flush_now       = 1'b0;
    last_grant_wr_d = last_grant_wr_q;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          flush_now = 1'b1;
        end else if (wr_elig && (!rd_elig || !last_grant_wr_q)) begin
          accept = 1'b1;
        end else if (rd_elig) begin
          start_rd = 1'b1;
          state_d  = StAddr;
        end
      end
      // A write issued the cycle we entered ADDR steals the port; re-present rd_ptr.
      StAddr: if (!mem_we_q) state_d = StLoad;
      StLoad: state_d = StWait;
      StWait: begin
        accept = wr_elig;
        pop    = done_send;
      end
      default: state_d = StIdle;
    endcase

    if (accept) last_grant_wr_d = 1'b1;
    else if (start_rd) last_grant_wr_d = 1'b0;

    count_d = count_q;
    if (accept) count_d = count_d + 1'b1;
    if (pop) count_d = count_d - 1'b1;
    if (flush_now) count_d = '0;

    if (pop) state_d = (!send_en_n && count_d != '0) ? StAddr : StIdle;

    wr_ptr_d = flush_now ? '0 : (accept ? ptr_inc(wr_ptr_q) : wr_ptr_q);
    rd_ptr_d = flush_now ? '0 : (pop ? ptr_inc(rd_ptr_q) : rd_ptr_q);

    mem_wdata_d = accept ? wr_data : mem_wdata_q;
    if (accept) mem_addr_d = wr_ptr_q;
    else if (state_d == StAddr || state_d == StLoad) mem_addr_d = rd_ptr_d;
    else mem_addr_d = mem_addr_q;
  end

  always_ff @(posedge clk_div or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_we_q        <= 1'b0;
      wr_ack_q        <= 1'b0;
      load_data_q     <= 1'b0;
      busy_q          <= 1'b0;
      last_grant_wr_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_we_q        <= accept;
      wr_ack_q        <= accept;
      load_data_q     <= (state_d == StLoad);
      busy_q          <= (state_d != StIdle);
      last_grant_wr_q <= last_grant_wr_d;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign load_data = load_data_q;
  assign count     = count_q;
  assign busy      = busy_q;

endmodule
